// File: rtl/if_id_hazard_ctrl_if.sv
// Control bundle between the IF/ID hazard sequencer and the surrounding pipeline stages.
interface if_id_hazard_ctrl_if #(
  parameter int unsigned REG_ADDR_LEN = 3,
  parameter int unsigned CNT_LEN      = 16
);
  logic [REG_ADDR_LEN-1:0] id_rs1;
  logic [REG_ADDR_LEN-1:0] id_rs2;
  logic                    id_uses_rs1;
  logic                    id_uses_rs2;
  logic                    ex_mem_read;
  logic [REG_ADDR_LEN-1:0] ex_rd;
  logic                    ex_branch_taken;
  logic                    imem_ready;
  logic                    pc_write;
  logic                    if_id_write;
  logic                    if_id_flush;
  logic                    id_ex_bubble;
  logic [CNT_LEN-1:0]      stall_cycles;
  logic [CNT_LEN-1:0]      flush_count;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
    output ex_mem_read, ex_rd, ex_branch_taken, imem_ready,
    input  pc_write, if_id_write, if_id_flush, id_ex_bubble,
    input  stall_cycles, flush_count
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
    input  ex_mem_read, ex_rd, ex_branch_taken, imem_ready,
    output pc_write, if_id_write, if_id_flush, id_ex_bubble,
    output stall_cycles, flush_count
  );
endinterface

// File: rtl/if_id_hazard_ctrl.sv
// IF/ID hazard sequencer: load-use stalls, taken-branch flushes and imem wait states,
// with saturating stall/flush performance counters.
module if_id_hazard_ctrl #(
  parameter int unsigned REG_ADDR_LEN    = 3,
  parameter int unsigned LOAD_USE_CYCLES = 1,
  parameter int unsigned CNT_LEN         = 16
) (
  input  logic                clk,
  input  logic                rst,
  if_id_hazard_ctrl_if.slave  bus
);

  typedef enum logic {RUN, LOAD_STALL} state_t;

  state_t             state, state_nxt;
  logic [2:0]         stall_left, stall_left_nxt;
  logic [CNT_LEN-1:0] stall_cnt, flush_cnt;
  logic               load_use;
  logic               inc_stall, inc_flush;
  logic               pc_write_c, if_id_write_c, if_id_flush_c, id_ex_bubble_c;

  assign load_use = bus.ex_mem_read &
                    ((bus.id_uses_rs1 & (bus.id_rs1 == bus.ex_rd)) |
                     (bus.id_uses_rs2 & (bus.id_rs2 == bus.ex_rd)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      stall_left <= '0;
    end else begin
      state      <= state_nxt;
      stall_left <= stall_left_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    stall_left_nxt  = stall_left;
    inc_stall       = 1'b0;
    inc_flush       = 1'b0;
    pc_write_c      = 1'b0;
    if_id_write_c   = 1'b0;
    if_id_flush_c   = 1'b0;
    id_ex_bubble_c  = 1'b0;
    if (bus.ex_branch_taken) begin
      pc_write_c     = 1'b1;
      if_id_flush_c  = 1'b1;
      id_ex_bubble_c = 1'b1;
      inc_flush      = 1'b1;
      state_nxt      = RUN;
      stall_left_nxt = '0;
    end else if (state == LOAD_STALL) begin
      // EX holds a bubble here, so a fresh load_use match cannot be real.
      id_ex_bubble_c = 1'b1;
      inc_stall      = 1'b1;
      stall_left_nxt = stall_left - 3'd1;
      if (stall_left == 3'd1)
        state_nxt = RUN;
    end else if (load_use) begin
      id_ex_bubble_c = 1'b1;
      inc_stall      = 1'b1;
      if (LOAD_USE_CYCLES > 1) begin
        state_nxt      = LOAD_STALL;
        stall_left_nxt = 3'(LOAD_USE_CYCLES - 1);
      end
    end else if (!bus.imem_ready) begin
      if_id_flush_c = 1'b1;
    end else begin
      pc_write_c    = 1'b1;
      if_id_write_c = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (inc_stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
      if (inc_flush && (flush_cnt != '1))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

  // Mealy outputs are forced low while reset is held, independent of inputs.
  assign bus.pc_write     = pc_write_c     & ~rst;
  assign bus.if_id_write  = if_id_write_c  & ~rst;
  assign bus.if_id_flush  = if_id_flush_c  & ~rst;
  assign bus.id_ex_bubble = id_ex_bubble_c & ~rst;
  assign bus.stall_cycles = stall_cnt;
  assign bus.flush_count  = flush_cnt;

endmodule

// File: tb/tb_if_id_hazard_ctrl.sv
// Directed bench driving three parameterisations of the hazard sequencer in lockstep.
module tb_if_id_hazard_ctrl;

  localparam logic [3:0] ZERO = 4'b0000;
  localparam logic [3:0] NORM = 4'b1100;  // {pc_write, if_id_write, if_id_flush, id_ex_bubble}
  localparam logic [3:0] STL  = 4'b0001;
  localparam logic [3:0] BR   = 4'b1011;
  localparam logic [3:0] WT   = 4'b0010;

  logic clk = 1'b0;
  logic rst;
  logic [2:0] id_rs1, id_rs2, ex_rd;
  logic id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken, imem_ready;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [3:0] e1;
    logic [3:0] e3;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  if_id_hazard_ctrl_if #(.REG_ADDR_LEN(3), .CNT_LEN(16)) bus1 ();
  if_id_hazard_ctrl_if #(.REG_ADDR_LEN(3), .CNT_LEN(16)) bus3 ();
  if_id_hazard_ctrl_if #(.REG_ADDR_LEN(3), .CNT_LEN(2))  buss ();

  if_id_hazard_ctrl #(.REG_ADDR_LEN(3), .LOAD_USE_CYCLES(1), .CNT_LEN(16))
    dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  if_id_hazard_ctrl #(.REG_ADDR_LEN(3), .LOAD_USE_CYCLES(3), .CNT_LEN(16))
    dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));
  if_id_hazard_ctrl #(.REG_ADDR_LEN(3), .LOAD_USE_CYCLES(1), .CNT_LEN(2))
    duts (.clk(clk), .rst(rst), .bus(buss.slave));

  assign bus1.id_rs1 = id_rs1;           assign bus3.id_rs1 = id_rs1;           assign buss.id_rs1 = id_rs1;
  assign bus1.id_rs2 = id_rs2;           assign bus3.id_rs2 = id_rs2;           assign buss.id_rs2 = id_rs2;
  assign bus1.id_uses_rs1 = id_uses_rs1; assign bus3.id_uses_rs1 = id_uses_rs1; assign buss.id_uses_rs1 = id_uses_rs1;
  assign bus1.id_uses_rs2 = id_uses_rs2; assign bus3.id_uses_rs2 = id_uses_rs2; assign buss.id_uses_rs2 = id_uses_rs2;
  assign bus1.ex_mem_read = ex_mem_read; assign bus3.ex_mem_read = ex_mem_read; assign buss.ex_mem_read = ex_mem_read;
  assign bus1.ex_rd = ex_rd;             assign bus3.ex_rd = ex_rd;             assign buss.ex_rd = ex_rd;
  assign bus1.ex_branch_taken = ex_branch_taken;
  assign bus3.ex_branch_taken = ex_branch_taken;
  assign buss.ex_branch_taken = ex_branch_taken;
  assign bus1.imem_ready = imem_ready;   assign bus3.imem_ready = imem_ready;   assign buss.imem_ready = imem_ready;

  wire [3:0] o1 = {bus1.pc_write, bus1.if_id_write, bus1.if_id_flush, bus1.id_ex_bubble};
  wire [3:0] o3 = {bus3.pc_write, bus3.if_id_write, bus3.if_id_flush, bus3.id_ex_bubble};
  wire [3:0] os = {buss.pc_write, buss.if_id_write, buss.if_id_flush, buss.id_ex_bubble};

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at posedge+1 with inputs already applied; compares mid-cycle, returns at next posedge+1.
  task automatic step(input string tag, input logic [3:0] e1, input logic [3:0] e3);
    exp_t e;
    sb.push_back('{tag, e1, e3});
    #3;
    e = sb.pop_front();
    chk({e.tag, "/luc1"}, int'(o1), int'(e.e1));
    chk({e.tag, "/luc3"}, int'(o3), int'(e.e3));
    chk({e.tag, "/sat"},  int'(os), int'(e.e1));
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_rs1 = 3'd1; id_rs2 = 3'd2; id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1;
    ex_mem_read = 1'b0; ex_rd = 3'd5; ex_branch_taken = 1'b0; imem_ready = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    @(posedge clk); #1;
    step("reset_outs", ZERO, ZERO);
    chk("reset_stall_cnt", int'(bus1.stall_cycles), 0);
    chk("reset_flush_cnt", int'(bus3.flush_count), 0);
    rst = 1'b0;
    step("normal", NORM, NORM);

    ex_mem_read = 1'b1; ex_rd = 3'd3; id_rs1 = 3'd3;
    step("load_use", STL, STL);
    chk("lu_cnt1", int'(bus1.stall_cycles), 1);
    idle_inputs();
    step("lu_after1", NORM, STL);
    step("lu_after2", NORM, STL);
    chk("lu_cnt3", int'(bus3.stall_cycles), 3);
    step("lu_done", NORM, NORM);
    chk("lu_cnt1_hold", int'(bus1.stall_cycles), 1);

    ex_mem_read = 1'b1; ex_rd = 3'd2; id_rs2 = 3'd2; id_uses_rs2 = 1'b0;
    step("no_match", NORM, NORM);

    ex_rd = 3'd0; id_rs1 = 3'd0;
    step("r0_stall", STL, STL);
    idle_inputs();
    ex_branch_taken = 1'b1;
    step("branch_in_stall", BR, BR);
    ex_branch_taken = 1'b0;
    step("after_branch", NORM, NORM);
    chk("br_flush_cnt", int'(bus3.flush_count), 1);
    chk("br_stall_cnt3", int'(bus3.stall_cycles), 4);
    chk("br_stall_cnt1", int'(bus1.stall_cycles), 2);

    imem_ready = 1'b0;
    for (int i = 0; i < 4; i++) step("imem_wait", WT, WT);
    imem_ready = 1'b1;
    step("imem_resume", NORM, NORM);

    ex_mem_read = 1'b1; ex_rd = 3'd3; id_rs1 = 3'd3; imem_ready = 1'b0;
    step("stall_vs_wait", STL, STL);
    idle_inputs(); imem_ready = 1'b0;
    step("wait_after_stall", WT, STL);
    imem_ready = 1'b1;
    step("retry_fetch", NORM, STL);
    step("settled", NORM, NORM);

    ex_branch_taken = 1'b1;
    for (int i = 0; i < 5; i++) step("flush_burst", BR, BR);
    ex_branch_taken = 1'b0;
    step("post_burst", NORM, NORM);
    chk("sat_flush_cnt", int'(buss.flush_count), 3);
    chk("wide_flush_cnt", int'(bus1.flush_count), 6);
    chk("sat_stall_cnt", int'(buss.stall_cycles), 3);

    ex_mem_read = 1'b1; ex_rd = 3'd3; id_rs1 = 3'd3;
    step("pre_reset_lu", STL, STL);
    idle_inputs();
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_outs3", int'(o3), int'(ZERO));
    chk("async_rst_outs1", int'(o1), int'(ZERO));
    chk("async_rst_cnt3", int'(bus3.stall_cycles), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    step("post_reset", NORM, NORM);
    chk("post_reset_cnt3", int'(bus3.stall_cycles), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
